// File: rtl/hand_pkg.sv
// Shared constants, types and helpers for the poker hand evaluator.
package hand_pkg;

    localparam int NUM_SUITS = 4;
    localparam int NUM_RANKS = 13;

    localparam logic [3:0] RANK_ACE     = 4'd0;
    localparam logic [3:0] VAL_ACE_HIGH = 4'd13;

    localparam logic [3:0] CAT_HIGH     = 4'd0;
    localparam logic [3:0] CAT_PAIR     = 4'd1;
    localparam logic [3:0] CAT_TWO_PAIR = 4'd2;
    localparam logic [3:0] CAT_TRIPS    = 4'd3;
    localparam logic [3:0] CAT_STRAIGHT = 4'd4;
    localparam logic [3:0] CAT_FLUSH    = 4'd5;
    localparam logic [3:0] CAT_FULL     = 4'd6;
    localparam logic [3:0] CAT_QUADS    = 4'd7;
    localparam logic [3:0] CAT_SFLUSH   = 4'd8;
    localparam logic [3:0] CAT_ROYAL    = 4'd9;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_EVAL,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [3:0]                k;
        logic [3:0]                run;
        logic [3:0]                str;
        logic [3:0]                sf;
        logic [NUM_SUITS-1:0][3:0] srun;
        logic [NUM_SUITS-1:0][3:0] fhi;
        logic [3:0]                quad;
        logic [3:0]                trip;
        logic [3:0]                trip2;
        logic [3:0]                pair;
        logic [3:0]                pair2;
        logic [3:0]                high;
    } scan_t;

    function automatic logic [3:0] rank_to_val(input logic [3:0] rank);
        return (rank == RANK_ACE) ? VAL_ACE_HIGH : rank;
    endfunction

endpackage

// File: rtl/hand_accum.sv
// Card collector: per-suit rank masks, card count and sticky hand error.
module hand_accum
    import hand_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear_i,
    input  logic                                accept_i,
    input  logic [3:0]                          rank_i,
    input  logic [1:0]                          suit_i,
    output logic [NUM_SUITS-1:0][NUM_RANKS-1:0] masks_o,
    output logic [CW-1:0]                       count_o,
    output logic                                err_o
);

    logic [NUM_SUITS-1:0][NUM_RANKS-1:0] masks_q, masks_d;
    logic [CW-1:0] count_q;
    logic          err_q;
    logic          illegal;
    logic          dup;

    assign illegal = (rank_i > 4'd12);
    assign dup     = !illegal && masks_q[suit_i][rank_i];

    always_comb begin
        masks_d = masks_q;
        if (!illegal && !dup) begin
            masks_d[suit_i][rank_i] = 1'b1;
        end
    end

    // Bad cards still count toward the hand so its length stays fixed.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            masks_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (accept_i) begin
            masks_q <= masks_d;
            count_q <= count_q + CW'(1);
            err_q   <= err_q | illegal | dup;
        end
    end

    assign masks_o = masks_q;
    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/hand_eval_seq.sv
// Sequential poker hand evaluator: load cards, scan 14 rank positions,
// then hold the registered category/top result until it is taken.
module hand_eval_seq
    import hand_pkg::*;
#(
    parameter int NUM_CARDS   = 5,
    parameter int HOLD_ON_ERR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_rank,
    input  logic [1:0] in_suit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_cat,
    output logic [3:0] out_top,
    output logic [7:0] out_score,
    output logic       out_err
);

    localparam int CW = $clog2(NUM_CARDS + 1);

    state_e state_q, state_d;
    scan_t  scan_q, scan_d;

    logic       out_valid_q, out_valid_d;
    logic       out_err_q, out_err_d;
    logic [3:0] out_cat_q, out_cat_d;
    logic [3:0] out_top_q, out_top_d;

    logic                                accept, clear, last;
    logic [NUM_SUITS-1:0][NUM_RANKS-1:0] masks;
    logic [CW-1:0]                       count;
    logic                                hand_err;

    logic [3:0]           pos_rank, pos_val;
    logic [NUM_SUITS-1:0] pres;
    logic [2:0]           mult;
    logic                 flush;
    logic [3:0]           flush_top, res_cat, res_top;

    assign in_ready = (state_q == ST_LOAD);
    assign accept   = in_valid && in_ready;
    assign last     = (count == CW'(NUM_CARDS - 1));

    hand_accum #(.CW(CW)) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .accept_i (accept),
        .rank_i   (in_rank),
        .suit_i   (in_suit),
        .masks_o  (masks),
        .count_o  (count),
        .err_o    (hand_err)
    );

    // Position 13 re-reads the ace so it can close an ace-high run.
    assign pos_rank = (scan_q.k == VAL_ACE_HIGH) ? RANK_ACE : scan_q.k;
    assign pos_val  = rank_to_val(pos_rank);

    always_comb begin
        for (int s = 0; s < NUM_SUITS; s++) begin
            pres[s] = masks[s][pos_rank];
        end
    end

    assign mult = 3'($countones(pres));

    always_comb begin
        flush     = 1'b0;
        flush_top = '0;
        for (int s = NUM_SUITS - 1; s >= 0; s--) begin
            if ($countones(masks[s]) >= 5) begin
                flush     = 1'b1;
                flush_top = scan_q.fhi[s];
            end
        end
        res_cat = CAT_HIGH;
        res_top = scan_q.high;
        if (hand_err) begin
            res_top = '0;
        end else if (scan_q.sf == VAL_ACE_HIGH) begin
            res_cat = CAT_ROYAL;
            res_top = scan_q.sf;
        end else if (scan_q.sf != '0) begin
            res_cat = CAT_SFLUSH;
            res_top = scan_q.sf;
        end else if (scan_q.quad != '0) begin
            res_cat = CAT_QUADS;
            res_top = scan_q.quad;
        end else if (scan_q.trip != '0 &&
                     (scan_q.pair != '0 || scan_q.trip2 != '0)) begin
            res_cat = CAT_FULL;
            res_top = scan_q.trip;
        end else if (flush) begin
            res_cat = CAT_FLUSH;
            res_top = flush_top;
        end else if (scan_q.str != '0) begin
            res_cat = CAT_STRAIGHT;
            res_top = scan_q.str;
        end else if (scan_q.trip != '0) begin
            res_cat = CAT_TRIPS;
            res_top = scan_q.trip;
        end else if (scan_q.pair2 != '0) begin
            res_cat = CAT_TWO_PAIR;
            res_top = scan_q.pair;
        end else if (scan_q.pair != '0) begin
            res_cat = CAT_PAIR;
            res_top = scan_q.pair;
        end
    end

    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        clear       = 1'b0;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_cat_d   = out_cat_q;
        out_top_d   = out_top_q;
        unique case (state_q)
            ST_LOAD: begin
                scan_d = '0;
                if (accept && last) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                scan_d.k   = scan_q.k + 4'd1;
                scan_d.run = (|pres) ? scan_q.run + 4'd1 : 4'd0;
                if (scan_d.run >= 4'd5) begin
                    scan_d.str = scan_q.k;
                end
                for (int s = 0; s < NUM_SUITS; s++) begin
                    scan_d.srun[s] = pres[s] ? scan_q.srun[s] + 4'd1 : 4'd0;
                    if (scan_d.srun[s] >= 4'd5) begin
                        scan_d.sf = scan_q.k;
                    end
                end
                // Ascending scan: the latest hit is always the highest.
                if (scan_q.k != 4'd0) begin
                    unique case (mult)
                        3'd4: scan_d.quad = pos_val;
                        3'd3: begin
                            scan_d.trip2 = scan_q.trip;
                            scan_d.trip  = pos_val;
                        end
                        3'd2: begin
                            scan_d.pair2 = scan_q.pair;
                            scan_d.pair  = pos_val;
                        end
                        default: ;
                    endcase
                    if (|pres) begin
                        scan_d.high = pos_val;
                    end
                    for (int s = 0; s < NUM_SUITS; s++) begin
                        if (pres[s]) begin
                            scan_d.fhi[s] = pos_val;
                        end
                    end
                end
                if (scan_q.k == VAL_ACE_HIGH) begin
                    if (hand_err && HOLD_ON_ERR == 0) begin
                        state_d = ST_LOAD;
                        clear   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_err_d   = hand_err;
                    out_cat_d   = res_cat;
                    out_top_d   = res_top;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                    clear       = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            scan_q      <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_cat_q   <= '0;
            out_top_q   <= '0;
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_cat_q   <= out_cat_d;
            out_top_q   <= out_top_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign out_cat   = out_cat_q;
    assign out_top   = out_top_q;
    assign out_score = {out_cat_q, out_top_q};

endmodule
